// File: rtl/life_pkg.sv
// Shared constants, rule presets and state classification for the life-like cell array.
package life_pkg;

    localparam int STATE_DEAD  = 0;
    localparam int STATE_ALIVE = 1;

    typedef struct packed {
        logic [8:0] birth;
        logic [8:0] survive;
        logic [4:0] states;
    } life_rule_t;

    localparam logic [8:0] RULE_B3S23_BIRTH   = 9'b0_0000_1000;
    localparam logic [8:0] RULE_B3S23_SURVIVE = 9'b0_0000_1100;

    // B2/S- with one dying state
    localparam life_rule_t RULE_BRIANS_BRAIN = '{
        birth:   9'b0_0000_0100,
        survive: 9'b0_0000_0000,
        states:  5'd3
    };

    typedef enum logic [1:0] {
        CELL_DEAD,
        CELL_ALIVE,
        CELL_DYING,
        CELL_INVALID
    } cell_kind_e;

    function automatic cell_kind_e classify(input int unsigned s, input int unsigned states);
        if (s == STATE_DEAD)
            return CELL_DEAD;
        else if (s == STATE_ALIVE)
            return CELL_ALIVE;
        else if (s < states)
            return CELL_DYING;
        else
            return CELL_INVALID;
    endfunction

endpackage

// File: rtl/life_cell_gen_neighbor_counter.sv
// Popcount of N single-bit inputs; result width is just wide enough for N.
module neighbor_counter #(
    parameter int N = 8
) (
    input  logic [N-1:0]           bits,
    output logic [$clog2(N+1)-1:0] count
);

    localparam int W = $clog2(N + 1);

    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < N; i++)
            count = count + W'(bits[i]);
    end

endmodule

// File: rtl/life_cell_gen.sv
// One grid site of a life-like cellular automaton with programmable B/S masks,
// Generations-style dying states, saturating age and a one-shot change flag.
module life_cell_gen
    import life_pkg::*;
#(
    parameter  int N_NEIGHBORS = 8,
    parameter  int STATES      = 2,
    parameter  int AGE_W       = 8,
    localparam int CNT_W       = $clog2(N_NEIGHBORS + 1),
    localparam int STATE_W     = (STATES > 2) ? $clog2(STATES) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ena,
    input  logic                   load,
    input  logic [STATE_W-1:0]     state_0,
    input  logic [N_NEIGHBORS:0]   birth_mask,
    input  logic [N_NEIGHBORS:0]   survive_mask,
    input  logic [N_NEIGHBORS-1:0] neighbors,
    output logic [STATE_W-1:0]     state_q,
    output logic [STATE_W-1:0]     state_d,
    output logic                   alive,
    output logic [AGE_W-1:0]       age,
    output logic                   changed
);

    localparam logic [STATE_W-1:0] DEAD_V  = STATE_W'(STATE_DEAD);
    localparam logic [STATE_W-1:0] ALIVE_V = STATE_W'(STATE_ALIVE);
    localparam logic [STATE_W-1:0] FIRST_DYING_V = (STATES > 2) ? STATE_W'(2) : DEAD_V;

    logic [CNT_W-1:0] count;
    cell_kind_e       kind;

    neighbor_counter #(.N(N_NEIGHBORS)) u_count (
        .bits  (neighbors),
        .count (count)
    );

    always_comb begin
        kind    = classify(32'(state_q), STATES);
        state_d = DEAD_V;
        unique case (kind)
            CELL_DEAD:  state_d = birth_mask[count] ? ALIVE_V : DEAD_V;
            CELL_ALIVE: state_d = survive_mask[count] ? ALIVE_V : FIRST_DYING_V;
            CELL_DYING: state_d = (32'(state_q) == STATES - 1) ? DEAD_V : state_q + STATE_W'(1);
            default:    state_d = DEAD_V;
        endcase
    end

    assign alive = (state_q == ALIVE_V);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DEAD_V;
            age     <= '0;
            changed <= 1'b0;
        end else if (load) begin
            // out-of-range seeds are clamped to dead rather than stored
            state_q <= (32'(state_0) >= STATES) ? DEAD_V : state_0;
            age     <= (state_0 == ALIVE_V) ? AGE_W'(1) : '0;
            changed <= 1'b0;
        end else if (ena) begin
            state_q <= state_d;
            changed <= (state_d != state_q);
            if (state_d != ALIVE_V)
                age <= '0;
            else if (state_q == ALIVE_V)
                age <= (age == '1) ? age : age + AGE_W'(1);
            else
                age <= AGE_W'(1);
        end else begin
            changed <= 1'b0;
        end
    end

endmodule

// File: tb/tb_life_cell_gen.sv
// Self-checking bench for life_cell_gen over three parameter sets.
module tb_life_cell_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Instance A: classic N=8, STATES=2, AGE_W=8
    logic       ena_a, load_a;
    logic [0:0] s0_a, a_q, a_d;
    logic [8:0] bm_a, sm_a;
    logic [7:0] nb_a, a_age;
    logic       a_alive, a_chg;

    // Instance G: N=8, STATES=4
    logic       ena_g, load_g;
    logic [1:0] s0_g, g_q, g_d;
    logic [8:0] bm_g, sm_g;
    logic [7:0] nb_g, g_age;
    logic       g_alive, g_chg;

    // Instance X: N=4, STATES=5, AGE_W=3
    logic       ena_x, load_x;
    logic [2:0] s0_x, x_q, x_d, x_age;
    logic [4:0] bm_x, sm_x;
    logic [3:0] nb_x;
    logic       x_alive, x_chg;

    life_cell_gen #(.N_NEIGHBORS(8), .STATES(2), .AGE_W(8)) u_a (
        .clk(clk), .rst(rst), .ena(ena_a), .load(load_a), .state_0(s0_a),
        .birth_mask(bm_a), .survive_mask(sm_a), .neighbors(nb_a),
        .state_q(a_q), .state_d(a_d), .alive(a_alive), .age(a_age), .changed(a_chg)
    );

    life_cell_gen #(.N_NEIGHBORS(8), .STATES(4), .AGE_W(8)) u_g (
        .clk(clk), .rst(rst), .ena(ena_g), .load(load_g), .state_0(s0_g),
        .birth_mask(bm_g), .survive_mask(sm_g), .neighbors(nb_g),
        .state_q(g_q), .state_d(g_d), .alive(g_alive), .age(g_age), .changed(g_chg)
    );

    life_cell_gen #(.N_NEIGHBORS(4), .STATES(5), .AGE_W(3)) u_x (
        .clk(clk), .rst(rst), .ena(ena_x), .load(load_x), .state_0(s0_x),
        .birth_mask(bm_x), .survive_mask(sm_x), .neighbors(nb_x),
        .state_q(x_q), .state_d(x_d), .alive(x_alive), .age(x_age), .changed(x_chg)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string name;
        int    sel;
        bit    ena;
        bit    load;
        int    s0;
        int    nb;
        int    bm;
        int    sm;
        int    eq;
        int    eage;
        bit    echg;
    } vec_t;

    typedef struct {
        string name;
        int    sel;
        int    eq;
        int    eage;
        bit    echg;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic void add(string n, int sel, bit ena, bit load, int s0, int nb,
                                int bm, int sm, int eq, int eage, bit echg);
        vecs.push_back('{n, sel, ena, load, s0, nb, bm, sm, eq, eage, echg});
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int rd_q(int sel);
        case (sel)
            0:       return int'(a_q);
            1:       return int'(g_q);
            default: return int'(x_q);
        endcase
    endfunction

    function automatic int rd_age(int sel);
        case (sel)
            0:       return int'(a_age);
            1:       return int'(g_age);
            default: return int'(x_age);
        endcase
    endfunction

    function automatic int rd_chg(int sel);
        case (sel)
            0:       return int'(a_chg);
            1:       return int'(g_chg);
            default: return int'(x_chg);
        endcase
    endfunction

    function automatic int rd_alive(int sel);
        case (sel)
            0:       return int'(a_alive);
            1:       return int'(g_alive);
            default: return int'(x_alive);
        endcase
    endfunction

    task automatic quiet();
        ena_a = 1'b0; load_a = 1'b0;
        ena_g = 1'b0; load_g = 1'b0;
        ena_x = 1'b0; load_x = 1'b0;
    endtask

    task automatic drive(vec_t v);
        quiet();
        case (v.sel)
            0: begin
                ena_a = v.ena; load_a = v.load; s0_a = 1'(v.s0);
                nb_a = 8'(v.nb); bm_a = 9'(v.bm); sm_a = 9'(v.sm);
            end
            1: begin
                ena_g = v.ena; load_g = v.load; s0_g = 2'(v.s0);
                nb_g = 8'(v.nb); bm_g = 9'(v.bm); sm_g = 9'(v.sm);
            end
            default: begin
                ena_x = v.ena; load_x = v.load; s0_x = 3'(v.s0);
                nb_x = 4'(v.nb); bm_x = 5'(v.bm); sm_x = 5'(v.sm);
            end
        endcase
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
            return;
        end
        e = sb.pop_front();
        check({e.name, ".state_q"}, rd_q(e.sel), e.eq);
        check({e.name, ".age"}, rd_age(e.sel), e.eage);
        check({e.name, ".changed"}, rd_chg(e.sel), int'(e.echg));
        check({e.name, ".alive"}, rd_alive(e.sel), (e.eq == 1) ? 1 : 0);
    endtask

    task automatic step(vec_t v);
        drive(v);
        sb.push_back('{v.name, v.sel, v.eq, v.eage, v.echg});
        @(posedge clk);
        #1;
        quiet();
        check_out();
    endtask

    initial begin
        vec_t v;

        quiet();
        s0_a = '0; nb_a = '0; bm_a = '0; sm_a = '0;
        s0_g = '0; nb_g = '0; bm_g = '0; sm_g = '0;
        s0_x = '0; nb_x = '0; bm_x = '0; sm_x = '0;

        // Classic B3/S23
        add("cls_idle0",      0, 0, 0, 0, 'h00, 'h008, 'h00C, 0, 0, 0);
        add("cls_birth",      0, 1, 0, 0, 'h07, 'h008, 'h00C, 1, 1, 1);
        add("cls_survive",    0, 1, 0, 0, 'h03, 'h008, 'h00C, 1, 2, 0);
        add("cls_overcrowd",  0, 1, 0, 0, 'hF0, 'h008, 'h00C, 0, 0, 1);
        add("cls_hold",       0, 0, 0, 0, 'h07, 'h008, 'h00C, 0, 0, 0);
        add("cls_stay_dead",  0, 1, 0, 0, 'h01, 'h008, 'h00C, 0, 0, 0);
        add("pri_load_wins",  0, 1, 1, 1, 'h00, 'h008, 'h00C, 1, 1, 0);
        add("pri_hold",       0, 0, 0, 0, 'h00, 'h008, 'h00C, 1, 1, 0);
        // Generations STATES=4, B2/S-
        add("gen_load_alive", 1, 0, 1, 1, 'h00, 'h004, 'h000, 1, 1, 0);
        add("gen_dying2",     1, 1, 0, 0, 'hFF, 'h004, 'h000, 2, 0, 1);
        add("gen_dying3",     1, 1, 0, 0, 'hFF, 'h004, 'h000, 3, 0, 1);
        add("gen_dead",       1, 1, 0, 0, 'hFF, 'h004, 'h000, 0, 0, 1);
        add("gen_no_birth8",  1, 1, 0, 0, 'hFF, 'h004, 'h000, 0, 0, 0);
        add("gen_birth2",     1, 1, 0, 0, 'h03, 'h004, 'h000, 1, 1, 1);
        add("gen_load_dying", 1, 0, 1, 3, 'hFF, 'h004, 'h000, 3, 0, 0);
        add("gen_last_dying", 1, 1, 0, 0, 'h03, 'h004, 'h000, 0, 0, 1);
        // N=4, STATES=5, AGE_W=3
        add("x_clamp7",       2, 0, 1, 7, 'h0, 'h10, 'h1F, 0, 0, 0);
        add("x_load4",        2, 0, 1, 4, 'h0, 'h10, 'h1F, 4, 0, 0);
        add("x_clamp5",       2, 0, 1, 5, 'h0, 'h10, 'h1F, 0, 0, 0);
        add("x_b4_born",      2, 1, 0, 0, 'hF, 'h10, 'h1F, 1, 1, 1);
        for (int k = 2; k <= 10; k++)
            add($sformatf("x_age%0d", k), 2, 1, 0, 0, 'h0, 'h10, 'h1F, 1, (k > 7) ? 7 : k, 0);
        add("x_load_dead",    2, 0, 1, 0, 'h0, 'h10, 'h1F, 0, 0, 0);
        add("x_b4_not3",      2, 1, 0, 0, 'h7, 'h10, 'h1F, 0, 0, 0);
        add("x_b0_born",      2, 1, 0, 0, 'h0, 'h01, 'h1F, 1, 1, 1);
        add("x_to_dying",     2, 1, 0, 0, 'h0, 'h01, 'h00, 2, 0, 1);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_a.state_q", int'(a_q), 0);
        check("rst_a.age", int'(a_age), 0);
        check("rst_g.state_q", int'(g_q), 0);
        check("rst_x.changed", int'(x_chg), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i])
            step(vecs[i]);

        // state_d is combinational: no edge between input change and check
        nb_a = 8'h00;
        #1 check("comb_a_die", int'(a_d), 0);
        nb_a = 8'h06;
        #1 check("comb_a_survive", int'(a_d), 1);
        nb_g = 8'h03;
        #1 check("comb_g_birth", int'(g_d), 1);
        nb_x = 4'hF;
        #1 check("comb_x_dying_ignores_nb", int'(x_d), 3);

        // Build age up to 37 on the classic cell
        v = '{"age_load", 0, 0, 1, 1, 'h00, 'h008, 'h00C, 1, 1, 0};
        step(v);
        for (int k = 2; k <= 37; k++) begin
            v = '{$sformatf("age_run%0d", k), 0, 1, 0, 0, 'h03, 'h008, 'h00C, 1, k, 0};
            step(v);
        end

        // Async reset mid-cycle, checked before any clock edge
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst.state_q", int'(a_q), 0);
        check("async_rst.age", int'(a_age), 0);
        check("async_rst.changed", int'(a_chg), 0);
        check("async_rst.alive", int'(a_alive), 0);

        // ena held through release: first edge evaluates birth from dead
        ena_a = 1'b1;
        nb_a  = 8'h07;
        @(negedge clk);
        #2;
        rst = 1'b1;
        sb.push_back('{"post_rst_birth", 0, 1, 1, 1'b1});
        @(posedge clk);
        #1;
        ena_a = 1'b0;
        check_out();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
